// File: rtl/alu_types.sv
// Shared ALU encodings plus the scoreboard's state encoding, mismatch bit
// positions and a 4-bit population count helper.
package alu_types;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10
    } alu_control_t;

    typedef logic [1:0] checker_state_t;

    localparam checker_state_t CHK_IDLE = 2'd0;
    localparam checker_state_t CHK_RUN  = 2'd1;
    localparam checker_state_t CHK_HALT = 2'd2;

    localparam int MISMATCH_RESULT   = 3;
    localparam int MISMATCH_OVERFLOW = 2;
    localparam int MISMATCH_ZERO     = 1;
    localparam int MISMATCH_EQUAL    = 0;

    function automatic logic [2:0] popcount4(input logic [3:0] m);
        popcount4 = 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a 0..4 increment and synchronous clear.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [2:0]       inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W:0] sum;

    assign sum = {1'b0, count} + (CNT_W+1)'(inc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (sum[CNT_W]) begin
            count <= '1;
        end else begin
            count <= sum[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/alu_hw_checker.sv
// Scoreboard comparing a DUT ALU against a reference ALU: registers the
// per-field compare at acceptance and updates counters/capture one cycle later.
module alu_hw_checker
    import alu_types::*;
#(
    parameter int N          = 32,
    parameter int N_OPS      = 11,
    parameter int MAX_ERRORS = 10,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             ovf_check_en,
    input  logic             valid,
    output logic             ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  alu_control_t     control,
    input  logic [N-1:0]     dut_result,
    input  logic [N-1:0]     ref_result,
    input  logic             dut_overflow,
    input  logic             dut_zero,
    input  logic             dut_equal,
    input  logic             ref_overflow,
    input  logic             ref_zero,
    input  logic             ref_equal,
    output checker_state_t   state,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] error_count,
    input  logic [3:0]       op_sel,
    output logic [CNT_W-1:0] op_err_count,
    output logic [3:0]       mismatch_mask,
    output logic             first_err_valid,
    output alu_control_t     first_err_op,
    output logic [N-1:0]     first_err_a,
    output logic [N-1:0]     first_err_b,
    output logic [3:0]       first_err_mask,
    output logic             bad_op
);

    checker_state_t   state_n;
    logic             accept;
    logic             clear;
    logic [3:0]       cmp_mask;
    logic             stg_valid;
    alu_control_t     stg_control;
    logic [N-1:0]     stg_a;
    logic [N-1:0]     stg_b;
    logic [3:0]       stg_mask;
    logic [2:0]       err_inc;
    logic [CNT_W:0]   err_sum;
    logic             halt_hit;
    logic [CNT_W-1:0] op_counts [N_OPS];

    assign accept = valid && ready;
    assign clear  = (state == CHK_IDLE) && start && !stop;

    // Case inequality so that X/Z on either side is reported as a mismatch.
    always_comb begin
        cmp_mask                    = 4'b0000;
        cmp_mask[MISMATCH_RESULT]   = (dut_result !== ref_result);
        cmp_mask[MISMATCH_OVERFLOW] = ovf_check_en && (dut_overflow !== ref_overflow);
        cmp_mask[MISMATCH_ZERO]     = (dut_zero !== ref_zero);
        cmp_mask[MISMATCH_EQUAL]    = (dut_equal !== ref_equal);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid   <= 1'b0;
            stg_control <= ALU_ADD;
            stg_a       <= '0;
            stg_b       <= '0;
            stg_mask    <= 4'b0000;
        end else begin
            stg_valid <= accept;
            if (accept) begin
                stg_control <= control;
                stg_a       <= a;
                stg_b       <= b;
                stg_mask    <= cmp_mask;
            end
        end
    end

    assign err_inc  = stg_valid ? popcount4(stg_mask) : 3'd0;
    assign err_sum  = {1'b0, error_count} + (CNT_W+1)'(err_inc);
    assign halt_hit = stg_valid && (err_sum > (CNT_W+1)'(MAX_ERRORS));

    always_comb begin
        state_n = state;
        case (state)
            CHK_IDLE: if (!stop && start) state_n = CHK_RUN;
            CHK_RUN: begin
                if (stop)          state_n = CHK_IDLE;
                else if (halt_hit) state_n = CHK_HALT;
            end
            CHK_HALT: if (stop) state_n = CHK_IDLE;
            default:  state_n = CHK_IDLE;
        endcase
    end

    // ready is a flop of the next state so it always mirrors state == RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CHK_IDLE;
            ready <= 1'b0;
        end else begin
            state <= state_n;
            ready <= (state_n == CHK_RUN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_mask   <= 4'b0000;
            bad_op          <= 1'b0;
            first_err_valid <= 1'b0;
            first_err_op    <= ALU_ADD;
            first_err_a     <= '0;
            first_err_b     <= '0;
            first_err_mask  <= 4'b0000;
        end else if (clear) begin
            mismatch_mask   <= 4'b0000;
            bad_op          <= 1'b0;
            first_err_valid <= 1'b0;
            first_err_op    <= ALU_ADD;
            first_err_a     <= '0;
            first_err_b     <= '0;
            first_err_mask  <= 4'b0000;
        end else if (stg_valid) begin
            mismatch_mask <= stg_mask;
            if (int'(stg_control) >= N_OPS) bad_op <= 1'b1;
            if (!first_err_valid && (stg_mask != 4'b0000)) begin
                first_err_valid <= 1'b1;
                first_err_op    <= stg_control;
                first_err_a     <= stg_a;
                first_err_b     <= stg_b;
                first_err_mask  <= stg_mask;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_sample_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .inc   ({2'b00, stg_valid}),
        .count (sample_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_error_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .inc   (err_inc),
        .count (error_count)
    );

    for (genvar g = 0; g < N_OPS; g++) begin : g_op
        logic [2:0] op_inc;
        assign op_inc = {2'b00, stg_valid && stg_mask[MISMATCH_RESULT] && (int'(stg_control) == g)};
        sat_counter #(.CNT_W(CNT_W)) u_op_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clear (clear),
            .inc   (op_inc),
            .count (op_counts[g])
        );
    end

    always_comb begin
        op_err_count = '0;
        for (int i = 0; i < N_OPS; i++) begin
            if (int'(op_sel) == i) op_err_count = op_counts[i];
        end
    end

endmodule

// File: doc/alu_hw_checker.md
Name: alu_hw_checker

Overview:
- Synthesizable, parametrised scoreboard that compares a DUT ALU against a reference ALU on a valid/ready sample stream.
- Per-field mismatch detection: result, overflow, zero, equal.
- Keeps a total error count and per-op error counters, and captures the first failing vector.
- Halts intake after MAX_ERRORS; sits beside the ALU on FPGA builds and in sequential benches.

Parameters:
N, 32, operand/result width
N_OPS, 11, number of alu_control_t encodings with per-op counters (indices 0..N_OPS-1)
MAX_ERRORS, 10, halt when error_count exceeds this
CNT_W, 16, width of all counters (saturating)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  IDLE->RUN, clears all counts/captures
stop  in  1  RUN/HALT->IDLE
ovf_check_en  in  1  1 = overflow field participates in compare
valid  in  1  sample present
ready  out  1  sample accepted when valid&&ready
a, b  in  N  operands of sample
control  in  alu_control_t  op of sample
dut_result / ref_result  in  N  results
dut_overflow, dut_zero, dut_equal / ref_overflow, ref_zero, ref_equal  in  1 each  flags
state  out  2  checker_state_t
sample_count  out  CNT_W  accepted samples
error_count  out  CNT_W  total field mismatches
op_sel  in  4  per-op counter read index
op_err_count  out  CNT_W  result mismatches for op_sel (combinational read)
mismatch_mask  out  4  {result,overflow,zero,equal} of last accepted sample
first_err_valid  out  1  capture registers hold data
first_err_op  out  alu_control_t  captured op
first_err_a, first_err_b  out  N  captured operands
first_err_mask  out  4  captured mask
bad_op  out  1  sticky: accepted sample with control >= N_OPS

Behaviour:
- Reset (async, rst_n=0): state=IDLE; every counter, mask, capture and bad_op = 0; ready=0.
- State machine, checker_state_t: IDLE=0, RUN=1, HALT=2.
  - IDLE: start -> RUN; on that same edge all counts, captures and bad_op clear.
  - RUN: stop -> IDLE. error_count > MAX_ERRORS after an update -> HALT.
  - HALT: stop -> IDLE; start ignored.
  - stop has priority over start.
  - start while in RUN is ignored; no clear.
- ready = (state==RUN), registered from state, so it falls the cycle after halt/stop.
- Sample accepted at edge T when valid&&ready. At T+1, from the registered compare:
  - mask bit = field inequality (!== in sim, so X counts as mismatch).
  - Overflow bit forced to 0 when ovf_check_en=0.
  - mismatch_mask is updated; sample_count += 1.
  - error_count += popcount(mask).
  - per_op[control] += 1 iff result bit set and control < N_OPS; control >= N_OPS sets bad_op instead.
- First error: on the first accepted sample with mask != 0, latch op, a, b, mask and set first_err_valid. Later errors never overwrite the capture.
- Latency: one cycle, sample edge to counter/mask/capture update. HALT is entered on the same edge as the update that crosses MAX_ERRORS.
- Sample in flight when stop asserts: still counted, since the compare stage completes.
- Counters saturate at 2^CNT_W-1, with no wrap.
- op_sel >= N_OPS reads 0.
- Mask is held when there is no sample.

Decomposition:
- alu_types package, existing: alu_control_t, plus new checker_state_t, MISMATCH_* bit indices, and function popcount4.
- One sub-module: sat_counter #(CNT_W), with increment amount 0..4 and synchronous clear. It is instantiated for sample_count, error_count and each per-op counter.

Test Plan:
1. Reset, then start. Send 20 samples with identical dut/ref outputs -> sample_count=20, error_count=0, first_err_valid=0, state=RUN.
2. Start, 3 clean samples, then ADD with a=1, b=2, dut_result=4, ref_result=3 (flags equal) -> next cycle mismatch_mask=1000, error_count=1, first_err_op=ADD, first_err_a=1, first_err_b=2, op_sel=ADD reads 1.
3. Overflow-only mismatch: with ovf_check_en=0 -> error_count unchanged; repeat with ovf_check_en=1 -> mask=0100, error_count+1, per_op unchanged.
4. MAX_ERRORS=10; feed 6 samples each mismatching result and zero (2 errors each) -> after the 6th sample error_count=12 and state=HALT. ready=0 the following cycle; later valid samples are not counted.
5. Mid-run rst_n low for half a cycle (asynchronous) -> all outputs 0 and state=IDLE immediately; start then resumes with clean counters.
6. Accept control=4'hF with N_OPS=11 and a result mismatch -> bad_op=1, error_count=1, no per-op counter changes. CNT_W=3 saturation check: sample_count stops at 7.
